fractal_sync_rx_ctrl: RTL and testbench

- Controller that sequences the two rx request FIFOs (left child, right child) of one fractal-sync tree node.
- Pops the FIFO heads in matched pairs with the same id and aggregate, and merges each pair into one request.
- Forwards the merged request upward over a valid/ready handshake.
- Detects unmatched heads with a timeout and drops them so a lost partner cannot deadlock the node.

---
 rtl/fractal_sync_rx_ctrl.sv | 154 +++++++++++++++
 tb/tb_fractal_sync_rx_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_rx_ctrl.sv
// fractal_sync_rx_ctrl: sequences the left/right rx request FIFOs of one
// fractal-sync tree node. Matching heads (same id and aggregate) are popped
// together, merged into one request and forwarded upward over valid/ready.
// A head that waits unmatched for TIMEOUT cycles is dropped so that a lost
// partner cannot deadlock the node (TIMEOUT = 0 waits forever).
// Optional statistics counters are compiled in with the macro
// FRACTAL_SYNC_RX_CTRL_STATS_EN.
module fractal_sync_rx_ctrl #(
  parameter int unsigned AGGR_W  = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned SRC_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              l_empty_i,
  input  logic [AGGR_W-1:0] l_aggr_i,
  input  logic [ID_W-1:0]   l_id_i,
  input  logic [SRC_W-1:0]  l_src_i,
  output logic              l_pop_o,
  input  logic              r_empty_i,
  input  logic [AGGR_W-1:0] r_aggr_i,
  input  logic [ID_W-1:0]   r_id_i,
  input  logic [SRC_W-1:0]  r_src_i,
  output logic              r_pop_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [AGGR_W-1:0] tx_aggr_o,
  output logic [ID_W-1:0]   tx_id_o,
  output logic [SRC_W-1:0]  tx_src_o,
  output logic              error_timeout_o,
`ifdef FRACTAL_SYNC_RX_CTRL_STATS_EN
  output logic [31:0]       sync_cnt_o,
  output logic [15:0]       drop_cnt_o,
`endif
  output logic              busy_o
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [AGGR_W-1:0]  aggr_q;
  logic [ID_W-1:0]    id_q;
  logic [SRC_W-1:0]   src_q;

  logic match;
  logic both_empty;
  logic take;
  logic drop;

  // Wait counter increment that sticks at TIMEOUT instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Merged sources: every leaf that took part in either child request.
  function automatic logic [SRC_W-1:0] merge_src(input logic [SRC_W-1:0] l,
                                                  input logic [SRC_W-1:0] r);
    return l | r;
  endfunction

  assign match = ~l_empty_i & ~r_empty_i & (l_id_i == r_id_i) & (l_aggr_i == r_aggr_i);
  assign both_empty = l_empty_i & r_empty_i;

  // Pop/drop decode; gated by reset so no FIFO is popped while the node is held in reset.
  always_comb begin
    take = 1'b0;
    drop = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE: take = match;
        WAIT: begin
          if (match) begin
            take = 1'b1;
          end else if (!both_empty && (TIMEOUT != 0) && (cnt_q == CNT_MAX)) begin
            drop = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign l_pop_o         = (take | drop) & ~l_empty_i;
  assign r_pop_o         = (take | drop) & ~r_empty_i;
  assign error_timeout_o = drop;

  assign tx_valid_o = (state_q == SEND);
  assign busy_o     = (state_q != IDLE);
  assign tx_aggr_o  = aggr_q;
  assign tx_id_o    = id_q;
  assign tx_src_o   = src_q;

  // Controller FSM: pair matching, unmatched-head timeout, upstream handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      aggr_q  <= '0;
      id_q    <= '0;
      src_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            aggr_q  <= l_aggr_i;
            id_q    <= l_id_i;
            src_q   <= merge_src(l_src_i, r_src_i);
            state_q <= SEND;
          end else if (!both_empty) begin
            cnt_q   <= CNT_W'(1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (take) begin
            aggr_q  <= l_aggr_i;
            id_q    <= l_id_i;
            src_q   <= merge_src(l_src_i, r_src_i);
            cnt_q   <= '0;
            state_q <= SEND;
          end else if (both_empty || drop) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q   <= sat_inc(cnt_q);
          end
        end
        SEND: begin
          if (tx_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FRACTAL_SYNC_RX_CTRL_STATS_EN
  // Completed handshakes and timeout drops; both wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (tx_valid_o && tx_ready_i) sync_cnt_o <= sync_cnt_o + 32'd1;
      if (error_timeout_o)          drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fractal_sync_rx_ctrl.sv
// Testbench for fractal_sync_rx_ctrl: left/right FIFOs are modelled as queues,
// a transaction-level reference predicts pops, timeouts and merged requests.
module tb_fractal_sync_rx_ctrl;
  localparam int AGGR_W  = 4;
  localparam int ID_W    = 2;
  localparam int SRC_W   = 4;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [3:0] aggr;
    logic [1:0] id;
    logic [3:0] src;
  } req_t;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              l_empty_i, r_empty_i;
  logic [AGGR_W-1:0] l_aggr_i, r_aggr_i;
  logic [ID_W-1:0]   l_id_i, r_id_i;
  logic [SRC_W-1:0]  l_src_i, r_src_i;
  logic              l_pop_o, r_pop_o;
  logic              tx_valid_o, tx_ready_i;
  logic [AGGR_W-1:0] tx_aggr_o;
  logic [ID_W-1:0]   tx_id_o;
  logic [SRC_W-1:0]  tx_src_o;
  logic              error_timeout_o, busy_o;
`ifdef FRACTAL_SYNC_RX_CTRL_STATS_EN
  logic [31:0]       sync_cnt_o;
  logic [15:0]       drop_cnt_o;
`endif

  fractal_sync_rx_ctrl #(
    .AGGR_W(AGGR_W), .ID_W(ID_W), .SRC_W(SRC_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .l_empty_i(l_empty_i), .l_aggr_i(l_aggr_i), .l_id_i(l_id_i), .l_src_i(l_src_i), .l_pop_o(l_pop_o),
    .r_empty_i(r_empty_i), .r_aggr_i(r_aggr_i), .r_id_i(r_id_i), .r_src_i(r_src_i), .r_pop_o(r_pop_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_aggr_o(tx_aggr_o), .tx_id_o(tx_id_o), .tx_src_o(tx_src_o),
    .error_timeout_o(error_timeout_o),
`ifdef FRACTAL_SYNC_RX_CTRL_STATS_EN
    .sync_cnt_o(sync_cnt_o), .drop_cnt_o(drop_cnt_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  req_t lq[$];
  req_t rq[$];

  // Reference: a merged request is held upstream, or heads have waited m_age cycles.
  bit   m_hold;
  int   m_age;
  req_t m_tx;
  int   m_sync, m_drop;

  int n_checks, n_fail;
  int rdy_mode;  // 0: ready low, 1: ready high, 2: random

  logic       obs_lpop, obs_rpop, obs_err, obs_valid, obs_busy;
  logic [9:0] obs_req;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_l(input logic [3:0] a, input logic [1:0] id, input logic [3:0] s);
    lq.push_back({a, id, s});
  endtask

  task automatic push_r(input logic [3:0] a, input logic [1:0] id, input logic [3:0] s);
    rq.push_back({a, id, s});
  endtask

  // Present the queue heads; an empty FIFO shows random garbage on its data lines.
  task automatic drive_heads();
    req_t h;
    l_empty_i = (lq.size() == 0);
    h = (lq.size() != 0) ? lq[0] : req_t'($urandom);
    {l_aggr_i, l_id_i, l_src_i} = h;
    r_empty_i = (rq.size() == 0);
    h = (rq.size() != 0) ? rq[0] : req_t'($urandom);
    {r_aggr_i, r_id_i, r_src_i} = h;
  endtask

  // One clock cycle: check outputs against the reference, then advance both.
  task automatic step();
    bit   le, re, mt, exp_lp, exp_rp, exp_err;
    req_t lh, rh;
    case (rdy_mode)
      0:       tx_ready_i = 1'b0;
      1:       tx_ready_i = 1'b1;
      default: tx_ready_i = 1'($urandom_range(1));
    endcase
    drive_heads();
    #1;
    check_val("tx_valid", tx_valid_o, m_hold);
    check_val("busy", busy_o, (m_hold || m_age > 0));
    if (m_hold) check_val("tx_req", {tx_aggr_o, tx_id_o, tx_src_o}, m_tx);
`ifdef FRACTAL_SYNC_RX_CTRL_STATS_EN
    check_val("sync_cnt", sync_cnt_o, m_sync);
    check_val("drop_cnt", drop_cnt_o, m_drop);
`endif
    le = (lq.size() == 0);
    re = (rq.size() == 0);
    lh = le ? req_t'(0) : lq[0];
    rh = re ? req_t'(0) : rq[0];
    mt = !le && !re && (lh.id == rh.id) && (lh.aggr == rh.aggr);
    exp_lp = 0; exp_rp = 0; exp_err = 0;
    if (m_hold) begin
    end else if (mt) begin
      exp_lp = 1; exp_rp = 1;
    end else if (m_age > 0 && !(le && re) && m_age == TIMEOUT) begin
      exp_lp = !le; exp_rp = !re; exp_err = 1;
    end
    check_val("l_pop", l_pop_o, exp_lp);
    check_val("r_pop", r_pop_o, exp_rp);
    check_val("error_timeout", error_timeout_o, exp_err);
    obs_lpop = l_pop_o; obs_rpop = r_pop_o; obs_err = error_timeout_o;
    obs_valid = tx_valid_o; obs_busy = busy_o;
    obs_req = {tx_aggr_o, tx_id_o, tx_src_o};
    @(posedge clk_i);
    #1;
    if (m_hold) begin
      if (tx_ready_i) begin m_hold = 0; m_sync++; end
    end else if (mt) begin
      m_tx = {lh.aggr, lh.id, lh.src | rh.src};
      m_hold = 1; m_age = 0;
    end else if (m_age == 0) begin
      if (!le || !re) m_age = 1;
    end else if (le && re) begin
      m_age = 0;
    end else if (exp_err) begin
      m_age = 0; m_drop++;
    end else begin
      m_age = (m_age < TIMEOUT) ? m_age + 1 : m_age;
    end
    if (exp_lp) void'(lq.pop_front());
    if (exp_rp) void'(rq.pop_front());
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      if (lq.size() == 0 && rq.size() == 0 && !m_hold && m_age == 0) break;
      step();
    end
    check_val("drain_idle", (lq.size() == 0 && rq.size() == 0 && !m_hold && m_age == 0), 1);
  endtask

  initial begin
    int npop, nerr, err_at, lpop_at, rpop_at, nvalid;
    bit sawr, sawv;
    n_checks = 0; n_fail = 0;
    m_hold = 0; m_age = 0; m_tx = '0; m_sync = 0; m_drop = 0;
    rdy_mode = 1; tx_ready_i = 1'b1;

    // Reset state, with a matching pair already visible: nothing may pop.
    push_l(4'h6, 2'd2, 4'h3);
    push_r(4'h6, 2'd2, 4'hC);
    drive_heads();
    #3;
    check_val("rst_l_pop", l_pop_o, 0);
    check_val("rst_r_pop", r_pop_o, 0);
    check_val("rst_valid", tx_valid_o, 0);
    check_val("rst_fields", {tx_aggr_o, tx_id_o, tx_src_o}, 0);
    check_val("rst_err", error_timeout_o, 0);
    check_val("rst_busy", busy_o, 0);
`ifdef FRACTAL_SYNC_RX_CTRL_STATS_EN
    check_val("rst_stats", {sync_cnt_o, drop_cnt_o}, 0);
`endif
    lq.delete(); rq.delete();
    drive_heads();
    #9 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Matched pair with ready high: pops at t, valid at t+1, idle at t+2.
    push_l(4'b0110, 2'd2, 4'b0011);
    push_r(4'b0110, 2'd2, 4'b1100);
    rdy_mode = 1;
    step(); check_val("t1_pops", {obs_lpop, obs_rpop}, 2'b11);
    step(); check_val("t1_valid", obs_valid, 1);
            check_val("t1_req", obs_req, 10'b0110_10_1111);
    step(); check_val("t1_busy", obs_busy, 0);
    drain();

    // Right partner arrives 5 cycles after the left head.
    push_l(4'h6, 2'd1, 4'h1);
    npop = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      npop += int'(obs_lpop) + int'(obs_rpop);
    end
    check_val("t2_no_pop", npop, 0);
    push_r(4'h6, 2'd1, 4'h2);
    step(); check_val("t2_pops", {obs_lpop, obs_rpop}, 2'b11);
    step(); check_val("t2_valid", obs_valid, 1);
    drain();

    // Lone left head times out exactly once, 8 cycles after leaving idle.
    push_l(4'h3, 2'd0, 4'h1);
    nerr = 0; err_at = -1; lpop_at = -1; sawr = 0; sawv = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (obs_err) begin nerr++; err_at = i; end
      if (obs_lpop) lpop_at = i;
      sawr |= obs_rpop; sawv |= obs_valid;
    end
    check_val("t3_nerr", nerr, 1);
    check_val("t3_err_at", err_at, 8);
    check_val("t3_lpop_at", lpop_at, 8);
    check_val("t3_no_rpop", sawr, 0);
    check_val("t3_no_valid", sawv, 0);
    drain();

    // Back-pressure: held request stays valid, next pair waits until after handshake.
    push_l(4'h5, 2'd3, 4'h1); push_r(4'h5, 2'd3, 4'h2);
    push_l(4'h5, 2'd3, 4'h4); push_r(4'h5, 2'd3, 4'h8);
    rdy_mode = 0;
    step(); check_val("t4_first_pops", {obs_lpop, obs_rpop}, 2'b11);
    npop = 0; nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      npop += int'(obs_lpop) + int'(obs_rpop);
      nvalid += int'(obs_valid);
    end
    check_val("t4_held_no_pop", npop, 0);
    check_val("t4_held_valid", nvalid, 10);
    rdy_mode = 1;
    step(); check_val("t4_hs_valid", obs_valid, 1);
            check_val("t4_hs_req", obs_req, 10'b0101_11_0011);
            check_val("t4_hs_no_pop", {obs_lpop, obs_rpop}, 2'b00);
    step(); check_val("t4_next_pops", {obs_lpop, obs_rpop}, 2'b11);
    drain();

    // Same id, different aggregate: both heads dropped together with one pulse.
    push_l(4'b0110, 2'd1, 4'h1);
    push_r(4'b0010, 2'd1, 4'h2);
    nerr = 0; lpop_at = -1; rpop_at = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (obs_err) nerr++;
      if (obs_lpop) lpop_at = i;
      if (obs_rpop) rpop_at = i;
    end
    check_val("t5_nerr", nerr, 1);
    check_val("t5_lpop_at", lpop_at, 8);
    check_val("t5_rpop_at", rpop_at, 8);
    drain();

    // Random traffic with random back-pressure.
    rdy_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] a, s1, s2;
      logic [1:0] id;
      a = ($urandom_range(1) != 0) ? 4'h6 : 4'h2;
      id = 2'($urandom_range(3));
      s1 = 4'($urandom); s2 = 4'($urandom);
      if (lq.size() < 8 && rq.size() < 8) begin
        case ($urandom_range(9))
          0, 1:    begin push_l(a, id, s1); push_r(a, id, s2); end
          2, 3:    push_l(a, id, s1);
          4, 5:    push_r(a, id, s2);
          default: ;
        endcase
      end
      step();
    end
    drain();

    // Reset during SEND drops the request at once and suppresses pops.
    push_l(4'h9, 2'd0, 4'h1); push_r(4'h9, 2'd0, 4'h2);
    rdy_mode = 0;
    step();
    push_l(4'h9, 2'd1, 4'h4); push_r(4'h9, 2'd1, 4'h8);
    drive_heads();
    #1;
    check_val("t6_pre_valid", tx_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    check_val("t6_valid_async", tx_valid_o, 0);
    check_val("t6_busy_async", busy_o, 0);
    check_val("t6_pops_in_rst", {l_pop_o, r_pop_o}, 2'b00);
`ifdef FRACTAL_SYNC_RX_CTRL_STATS_EN
    check_val("t6_sync_cnt", sync_cnt_o, 0);
    check_val("t6_drop_cnt", drop_cnt_o, 0);
`endif
    m_hold = 0; m_age = 0; m_sync = 0; m_drop = 0;
    @(posedge clk_i); #1;
    check_val("t6_pops_edge_rst", {l_pop_o, r_pop_o}, 2'b00);
    check_val("t6_valid_edge_rst", tx_valid_o, 0);
    rst_ni = 1'b1;
    rdy_mode = 1;
    step(); check_val("t6_post_pops", {obs_lpop, obs_rpop}, 2'b11);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
